dpb_jpeg_packer: RTL and testbench

Upstream stage of the DPB-to-UDP path. Accepts the MJPEG encoder byte stream and packs it big-endian into 128-bit words. Writes those words through port A of the 2048×128 dual-port BRAM, using 16 slots of 128 words each. Each filled slot becomes one UDP chunk, announced to the DPB master command block through the `wr_req` / `wr_down` handshake together with the chunk's length, rank and last-of-frame flag.

---
 rtl/dpb_jpeg_packer_if.sv | 57 +++++
 rtl/dpb_jpeg_packer.sv | 230 +++++++++++++++++++++++
 tb/tb_dpb_jpeg_packer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dpb_jpeg_packer_if.sv
// dpb_jpeg_packer_if
// Bundles every non-clock signal of the JPEG packer: the byte stream in,
// BRAM port A out, and the chunk request/release handshake with the DPB
// master command block.
//
// Handshakes:
//   byte stream : a byte moves on a cycle where i_jpeg_valid & o_jpeg_ready;
//                 o_jpeg_ready does not depend on i_jpeg_valid, and the
//                 producer holds data/sof/eof stable while valid is high and
//                 ready is low.
//   chunk       : o_wr_req pulses once when the o_wr_* fields become valid;
//                 the fields stay stable until the consumer pulses i_wr_down.
//                 At most one request is outstanding.
//
// master : the packer (drives o_*)
// slave  : the environment (drives i_*)
interface dpb_jpeg_packer_if;
  logic         i_jpeg_valid;
  logic [7:0]   i_jpeg_data;
  logic         i_jpeg_sof;
  logic         i_jpeg_eof;
  logic         o_jpeg_ready;

  logic         o_dpb_a_clk;
  logic         o_dpb_a_cea;
  logic         o_dpb_a_wr_en;
  logic [10:0]  o_dpb_a_addr;
  logic [127:0] o_dpb_a_wr_data;

  logic         o_wr_req;
  logic         o_wr_frame_down;
  logic [7:0]   o_wr_udp_rank;
  logic [3:0]   o_wr_buf_rank;
  logic [6:0]   o_wr_buf_128cnt;
  logic [5:0]   o_wr_buf_Bytecnt;
  logic         i_wr_down;

  logic [4:0]   o_slots_used;
  logic         o_sof_err;
  logic         o_dbg_state;   // dispatch FSM state: 0 = IDLE, 1 = WAIT

  modport master (
    input  i_jpeg_valid, i_jpeg_data, i_jpeg_sof, i_jpeg_eof, i_wr_down,
    output o_jpeg_ready, o_dpb_a_clk, o_dpb_a_cea, o_dpb_a_wr_en,
           o_dpb_a_addr, o_dpb_a_wr_data, o_wr_req, o_wr_frame_down,
           o_wr_udp_rank, o_wr_buf_rank, o_wr_buf_128cnt, o_wr_buf_Bytecnt,
           o_slots_used, o_sof_err, o_dbg_state
  );

  modport slave (
    output i_jpeg_valid, i_jpeg_data, i_jpeg_sof, i_jpeg_eof, i_wr_down,
    input  o_jpeg_ready, o_dpb_a_clk, o_dpb_a_cea, o_dpb_a_wr_en,
           o_dpb_a_addr, o_dpb_a_wr_data, o_wr_req, o_wr_frame_down,
           o_wr_udp_rank, o_wr_buf_rank, o_wr_buf_128cnt, o_wr_buf_Bytecnt,
           o_slots_used, o_sof_err, o_dbg_state
  );
endinterface

// File: rtl/dpb_jpeg_packer.sv
// dpb_jpeg_packer
// Packs the MJPEG byte stream big-endian into 128-bit words, writes them into
// 16 slots of a 2048x128 BRAM (port A, address {slot, word}, word 0 unused)
// and announces each closed slot as one UDP chunk to the DPB master.
//
// Ports:
//   i_pclk   : clock, also BRAM port A clock
//   i_rst_n  : asynchronous active-low reset
//   bus      : dpb_jpeg_packer_if.master (byte stream, BRAM port A,
//              chunk request/release, slot occupancy, SOF error, FSM state)
module dpb_jpeg_packer #(
  parameter int unsigned PKT_WORDS = 64,
  parameter logic [7:0]  PAD_BYTE  = 8'h00
) (
  input  logic              i_pclk,
  input  logic              i_rst_n,
  dpb_jpeg_packer_if.master bus
);
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [6:0]   LAST_WORD = 7'(PKT_WORDS);
  localparam logic [127:0] PAD_WORD  = {16{PAD_BYTE}};

  // fill stage
  logic [3:0]   lane_q;
  logic [6:0]   word_q;
  logic [3:0]   fill_slot_q;
  logic [7:0]   rank_q;
  logic         in_frame_q;
  logic [127:0] word_buf_q;
  logic         ready_en_q;

  // write stage
  logic         wr_en_q;
  logic [10:0]  addr_q;
  logic [127:0] data_q;
  logic         sof_err_q;
  logic         close_q;
  logic [3:0]   close_slot_q;
  logic         close_last_q;
  logic [7:0]   close_rank_q;
  logic [6:0]   close_cnt_q;
  logic [5:0]   close_bytes_q;

  // per-slot chunk metadata (not reset)
  logic         meta_last  [16];
  logic [7:0]   meta_rank  [16];
  logic [6:0]   meta_cnt   [16];
  logic [5:0]   meta_bytes [16];

  // dispatch
  logic [4:0]   used_q;
  logic [3:0]   rd_slot_q;
  state_t       state_q, state_d;
  logic         load, rel;
  logic         req_q, last_q;
  logic [7:0]   f_rank_q;
  logic [3:0]   f_buf_q;
  logic [6:0]   f_cnt_q;
  logic [5:0]   f_bytes_q;

  // fill-side combinational decode
  logic         accept, take, partial, sof_abort, do_write, do_close;
  logic [3:0]   lane_eff;
  logic [6:0]   word_eff;
  logic [7:0]   rank_eff;
  logic [127:0] word_nxt;

  always_comb begin
    accept    = bus.i_jpeg_valid & bus.o_jpeg_ready;
    // bytes outside a frame are consumed but never stored
    take      = accept & (in_frame_q | bus.i_jpeg_sof);
    partial   = in_frame_q & ((lane_q != 4'd0) | (word_q != 7'd1));
    sof_abort = take & bus.i_jpeg_sof & partial;
    // an SOF byte restarts the chunk in place: lane 0, word 1, rank 0
    lane_eff  = bus.i_jpeg_sof ? 4'd0 : lane_q;
    word_eff  = bus.i_jpeg_sof ? 7'd1 : word_q;
    rank_eff  = bus.i_jpeg_sof ? 8'd0 : rank_q;
    word_nxt  = bus.i_jpeg_sof ? PAD_WORD : word_buf_q;
    for (int i = 0; i < 16; i++) begin
      if (lane_eff == 4'(i)) word_nxt[127-8*i -: 8] = bus.i_jpeg_data;
    end
    do_write  = take & ((lane_eff == 4'd15) | bus.i_jpeg_eof);
    do_close  = do_write & (bus.i_jpeg_eof | (word_eff == LAST_WORD));
  end

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lane_q        <= '0;
      word_q        <= 7'd1;
      fill_slot_q   <= '0;
      rank_q        <= '0;
      in_frame_q    <= 1'b0;
      word_buf_q    <= PAD_WORD;
      ready_en_q    <= 1'b0;
      wr_en_q       <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      sof_err_q     <= 1'b0;
      close_q       <= 1'b0;
      close_slot_q  <= '0;
      close_last_q  <= 1'b0;
      close_rank_q  <= '0;
      close_cnt_q   <= '0;
      close_bytes_q <= '0;
    end else begin
      ready_en_q <= 1'b1;
      wr_en_q    <= do_write;
      sof_err_q  <= sof_abort;
      close_q    <= do_close;
      if (do_write) begin
        addr_q <= {fill_slot_q, word_eff};
        data_q <= word_nxt;
      end
      if (do_close) begin
        close_slot_q  <= fill_slot_q;
        close_last_q  <= bus.i_jpeg_eof;
        close_rank_q  <= rank_eff;
        // a word ending before lane 15 is the partial word of the chunk
        close_cnt_q   <= (lane_eff == 4'd15) ? word_eff : word_eff - 7'd1;
        close_bytes_q <= (lane_eff == 4'd15) ? 6'd0 : {2'b00, lane_eff} + 6'd1;
      end
      if (take) begin
        in_frame_q <= ~bus.i_jpeg_eof;
        if (do_close) begin
          lane_q      <= '0;
          word_q      <= 7'd1;
          fill_slot_q <= fill_slot_q + 4'd1;
          rank_q      <= bus.i_jpeg_eof ? rank_eff : rank_eff + 8'd1;
          word_buf_q  <= PAD_WORD;
        end else if (do_write) begin
          lane_q      <= '0;
          word_q      <= word_eff + 7'd1;
          rank_q      <= rank_eff;
          word_buf_q  <= PAD_WORD;
        end else begin
          lane_q      <= lane_eff + 4'd1;
          word_q      <= word_eff;
          rank_q      <= rank_eff;
          word_buf_q  <= word_nxt;
        end
      end
    end
  end

  always_ff @(posedge i_pclk) begin
    if (close_q) begin
      meta_last[close_slot_q]  <= close_last_q;
      meta_rank[close_slot_q]  <= close_rank_q;
      meta_cnt[close_slot_q]   <= close_cnt_q;
      meta_bytes[close_slot_q] <= close_bytes_q;
    end
  end

  // occupancy: a close and a release in the same cycle cancel out
  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      used_q    <= '0;
      rd_slot_q <= '0;
    end else begin
      case ({close_q, rel})
        2'b10:   used_q <= used_q + 5'd1;
        2'b01:   used_q <= used_q - 5'd1;
        default: used_q <= used_q;
      endcase
      if (rel) rd_slot_q <= rd_slot_q + 4'd1;
    end
  end

  // dispatch FSM: state register
  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // dispatch FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (used_q != 5'd0) state_d = S_WAIT;
      S_WAIT:  if (bus.i_wr_down)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // dispatch FSM: outputs. In IDLE every counted slot is still unannounced.
  always_comb begin
    load = (state_q == S_IDLE) & (used_q != 5'd0);
    rel  = (state_q == S_WAIT) & bus.i_wr_down;
  end

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_q     <= 1'b0;
      last_q    <= 1'b0;
      f_rank_q  <= '0;
      f_buf_q   <= '0;
      f_cnt_q   <= '0;
      f_bytes_q <= '0;
    end else begin
      req_q <= load;
      if (load) begin
        last_q    <= meta_last[rd_slot_q];
        f_rank_q  <= meta_rank[rd_slot_q];
        f_buf_q   <= rd_slot_q;
        f_cnt_q   <= meta_cnt[rd_slot_q];
        f_bytes_q <= meta_bytes[rd_slot_q];
      end
    end
  end

  // With 15 slots counted and a close in the write stage, the fill slot is
  // about to become the slot under read, so stop one cycle early.
  assign bus.o_jpeg_ready     = ready_en_q & ~((used_q == 5'd16) |
                                               ((used_q == 5'd15) & close_q));
  assign bus.o_dpb_a_clk      = i_pclk;
  assign bus.o_dpb_a_cea      = 1'b1;
  assign bus.o_dpb_a_wr_en    = wr_en_q;
  assign bus.o_dpb_a_addr     = addr_q;
  assign bus.o_dpb_a_wr_data  = data_q;
  assign bus.o_wr_req         = req_q;
  assign bus.o_wr_frame_down  = (state_q == S_WAIT) & last_q;
  assign bus.o_wr_udp_rank    = f_rank_q;
  assign bus.o_wr_buf_rank    = f_buf_q;
  assign bus.o_wr_buf_128cnt  = f_cnt_q;
  assign bus.o_wr_buf_Bytecnt = f_bytes_q;
  assign bus.o_slots_used     = used_q;
  assign bus.o_sof_err        = sof_err_q;
  assign bus.o_dbg_state      = state_q;
endmodule

// File: tb/tb_dpb_jpeg_packer.sv
module tb_dpb_jpeg_packer;
  localparam int         P     = 64;
  localparam logic [7:0] PAD   = 8'h00;
  localparam int         CHUNK = P * 16;

  // clock / reset
  logic i_pclk  = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_pclk = ~i_pclk;

  dpb_jpeg_packer_if bus();

  dpb_jpeg_packer #(.PKT_WORDS(P), .PAD_BYTE(PAD)) dut (
    .i_pclk  (i_pclk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  // scoreboard state
  int           checks = 0;
  int           errors = 0;
  logic [138:0] exp_q[$];      // {addr, data} of expected BRAM writes
  logic [25:0]  exp_req_q[$];  // {last, slot, rank, 128cnt, Bytecnt}
  logic [7:0]   fb[$];         // current frame bytes
  int           m_slot = 0;
  int           sof_err_exp = 0;
  int           sof_err_seen = 0;
  bit           hold_down = 1'b0;
  int           poke_req = 0;
  int           poke_done = 0;
  logic         cur_last = 1'b0;
  logic [138:0] wr_e;
  logic [25:0]  req_e;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: a frame is cut into CHUNK-byte pieces; each piece fills
  // words 1.. of the next slot, the tail word padded with PAD
  task automatic model_frame(input int len, input bit complete);
    int rank;
    rank = 0;
    for (int off = 0; off < len; off += CHUNK) begin
      int n, nw;
      logic [127:0] d;
      n  = (len - off < CHUNK) ? len - off : CHUNK;
      nw = complete ? (n + 15) / 16 : n / 16;
      for (int w = 0; w < nw; w++) begin
        d = {16{PAD}};
        for (int b = 0; b < 16; b++)
          if (w * 16 + b < n) d[127-8*b -: 8] = fb[off + w * 16 + b];
        exp_q.push_back({4'(m_slot), 7'(w + 1), d});
      end
      if (complete || n == CHUNK) begin
        exp_req_q.push_back({1'(complete && (off + n == len)), 4'(m_slot),
                             8'(rank), 7'(n / 16), 6'(n % 16)});
        m_slot = (m_slot + 1) % 16;
        rank   = (rank + 1) % 256;
      end
    end
  endtask

  task automatic gen_frame(input int len);
    fb.delete();
    for (int i = 0; i < len; i++) fb.push_back(8'($urandom_range(0, 255)));
  endtask

  // driver: called at a negedge, returns at the negedge after acceptance
  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    int n;
    n = 0;
    bus.i_jpeg_valid = 1'b1;
    bus.i_jpeg_data  = d;
    bus.i_jpeg_sof   = s;
    bus.i_jpeg_eof   = e;
    while (!bus.o_jpeg_ready && n < 5000) begin
      @(negedge i_pclk);
      n++;
    end
    if (n >= 5000) check("ready_timeout", 128'(bus.o_jpeg_ready), 128'(1));
    @(negedge i_pclk);
    bus.i_jpeg_valid = 1'b0;
    bus.i_jpeg_sof   = 1'b0;
    bus.i_jpeg_eof   = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit complete);
    for (int i = 0; i < len; i++)
      send_byte(fb[i], i == 0, complete && (i == len - 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_req_q.size() != 0 ||
            bus.o_slots_used != 5'd0 || bus.o_dbg_state != 1'b0) && n < 20000) begin
      @(negedge i_pclk);
      n++;
    end
    check("drain_wr_q", 128'(exp_q.size()), 128'(0));
    check("drain_req_q", 128'(exp_req_q.size()), 128'(0));
    check("drain_used", 128'(bus.o_slots_used), 128'(0));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req"}, 128'(bus.o_wr_req), 128'(0));
    check({tag, "_used"}, 128'(bus.o_slots_used), 128'(0));
    check({tag, "_buf"}, 128'(bus.o_wr_buf_rank), 128'(0));
    check({tag, "_rank"}, 128'(bus.o_wr_udp_rank), 128'(0));
    check({tag, "_cnt"}, 128'(bus.o_wr_buf_128cnt), 128'(0));
    check({tag, "_bytes"}, 128'(bus.o_wr_buf_Bytecnt), 128'(0));
    check({tag, "_fdown"}, 128'(bus.o_wr_frame_down), 128'(0));
    check({tag, "_wr_en"}, 128'(bus.o_dpb_a_wr_en), 128'(0));
    check({tag, "_ready"}, 128'(bus.o_jpeg_ready), 128'(0));
    check({tag, "_cea"}, 128'(bus.o_dpb_a_cea), 128'(1));
  endtask

  // write monitor
  always @(negedge i_pclk) begin
    if (i_rst_n && bus.o_dpb_a_wr_en) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 128'(bus.o_dpb_a_addr), 128'(0));
        check("wr_unexpected_q", 128'(exp_q.size()), 128'(1));
      end else begin
        wr_e = exp_q.pop_front();
        check("wr_addr", 128'(bus.o_dpb_a_addr), 128'(wr_e[138:128]));
        check("wr_data", bus.o_dpb_a_wr_data, wr_e[127:0]);
      end
    end
  end

  // request monitor
  always @(negedge i_pclk) begin
    if (i_rst_n && bus.o_wr_req) begin
      if (exp_req_q.size() == 0) begin
        check("req_unexpected_q", 128'(exp_req_q.size()), 128'(1));
      end else begin
        req_e = exp_req_q.pop_front();
        cur_last = req_e[25];
        check("req_fdown", 128'(bus.o_wr_frame_down), 128'(req_e[25]));
        check("req_buf", 128'(bus.o_wr_buf_rank), 128'(req_e[24:21]));
        check("req_rank", 128'(bus.o_wr_udp_rank), 128'(req_e[20:13]));
        check("req_cnt", 128'(bus.o_wr_buf_128cnt), 128'(req_e[12:6]));
        check("req_bytes", 128'(bus.o_wr_buf_Bytecnt), 128'(req_e[5:0]));
      end
    end else if (i_rst_n && bus.o_dbg_state) begin
      check("fdown_hold", 128'(bus.o_wr_frame_down), 128'(cur_last));
    end
    if (i_rst_n && bus.o_sof_err) sof_err_seen++;
  end

  // consumer: releases each request after a short random delay
  bit waiting = 1'b0;
  int delay   = 0;
  initial begin
    bus.i_wr_down = 1'b0;
    forever begin
      @(negedge i_pclk);
      bus.i_wr_down = 1'b0;
      if (!i_rst_n) begin
        waiting = 1'b0;
        delay   = 0;
      end else begin
        if (bus.o_wr_req) begin
          waiting = 1'b1;
          delay   = $urandom_range(0, 3);
        end
        if (poke_req != poke_done) begin
          bus.i_wr_down = 1'b1;
          poke_done = poke_req;
        end else if (waiting && !hold_down) begin
          if (delay == 0) begin
            bus.i_wr_down = 1'b1;
            waiting = 1'b0;
          end else begin
            delay--;
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    int n, len;
    bit abort;
    bus.i_jpeg_valid = 1'b0;
    bus.i_jpeg_data  = 8'h00;
    bus.i_jpeg_sof   = 1'b0;
    bus.i_jpeg_eof   = 1'b0;
    repeat (3) @(negedge i_pclk);
    check_zero_outputs("reset");
    check("reset_sof_err", 128'(bus.o_sof_err), 128'(0));
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_pclk);

    // 16 bytes 00..0F with EOF on the last
    fb.delete();
    for (int i = 0; i < 16; i++) fb.push_back(8'(i));
    model_frame(16, 1'b1);
    send_frame(16, 1'b1);

    // 3-byte frame
    fb.delete();
    fb.push_back(8'hAA); fb.push_back(8'hBB); fb.push_back(8'hCC);
    model_frame(3, 1'b1);
    send_frame(3, 1'b1);

    // one-byte frame (SOF and EOF together)
    fb.delete();
    fb.push_back(8'h5A);
    model_frame(1, 1'b1);
    send_frame(1, 1'b1);

    // 2000-byte frame: two chunks
    gen_frame(2000);
    model_frame(2000, 1'b1);
    send_frame(2000, 1'b1);

    // SOF after 40 bytes of an open chunk
    gen_frame(40);
    model_frame(40, 1'b0);
    send_frame(40, 1'b0);
    gen_frame(300);
    model_frame(300, 1'b1);
    sof_err_exp++;
    send_byte(fb[0], 1'b1, 1'b0);
    check("sof_err_pulse", 128'(bus.o_sof_err), 128'(1));
    for (int i = 1; i < 300; i++) send_byte(fb[i], 1'b0, i == 299);
    drain();

    // release strobe in IDLE must be ignored
    poke_req++;
    repeat (5) @(negedge i_pclk);
    check("idle_down_used", 128'(bus.o_slots_used), 128'(0));
    check("idle_down_state", 128'(bus.o_dbg_state), 128'(0));

    // backpressure: 16 unreleased chunks
    hold_down = 1'b1;
    for (int f = 0; f < 16; f++) begin
      gen_frame($urandom_range(1, 40));
      model_frame(fb.size(), 1'b1);
      send_frame(fb.size(), 1'b1);
    end
    n = 0;
    while (bus.o_slots_used != 5'd16 && n < 200) begin
      @(negedge i_pclk);
      n++;
    end
    check("full_used", 128'(bus.o_slots_used), 128'(16));
    check("full_ready", 128'(bus.o_jpeg_ready), 128'(0));
    repeat (10) @(negedge i_pclk);
    check("full_ready_hold", 128'(bus.o_jpeg_ready), 128'(0));
    hold_down = 1'b0;
    n = 0;
    while (bus.o_slots_used == 5'd16 && n < 200) begin
      @(negedge i_pclk);
      n++;
    end
    check("release_used", 128'(bus.o_slots_used), 128'(15));
    check("release_ready", 128'(bus.o_jpeg_ready), 128'(1));
    drain();

    // randomized frames, some cut short by the next SOF
    for (int f = 0; f < 20; f++) begin
      abort = (f < 19) && ($urandom_range(0, 9) == 0);
      len = $urandom_range(1, 1500);
      gen_frame(len);
      if (abort && (len % CHUNK != 0)) sof_err_exp++;
      model_frame(len, !abort);
      send_frame(len, !abort);
      repeat ($urandom_range(0, 3)) @(negedge i_pclk);
    end
    drain();
    check("sof_err_count", 128'(sof_err_seen), 128'(sof_err_exp));

    // reset while a request is outstanding
    hold_down = 1'b1;
    gen_frame(20);
    model_frame(20, 1'b1);
    send_frame(20, 1'b1);
    n = 0;
    while (bus.o_dbg_state != 1'b1 && n < 100) begin
      @(negedge i_pclk);
      n++;
    end
    check("pre_reset_wait", 128'(bus.o_dbg_state), 128'(1));
    repeat (2) @(negedge i_pclk);
    i_rst_n = 1'b0;
    #1;
    check_zero_outputs("mid_reset");
    exp_q.delete();
    exp_req_q.delete();
    m_slot = 0;
    hold_down = 1'b0;
    @(negedge i_pclk);
    i_rst_n = 1'b1;
    @(negedge i_pclk);
    gen_frame(50);
    model_frame(50, 1'b1);
    send_frame(50, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
